// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a single-entry
// registered output stage. The arbiter picks one requesting channel per cycle
// by round-robin, fixed priority or a forced select. The output register
// refills in the same cycle it drains, so a full stream runs without bubbles.
module stream_mux_rr #(
    parameter int NCH       = 4,
    parameter int DW        = 8,
    parameter int FIXED_PRI = 0,
    parameter int CW        = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*DW-1:0]   in_data,
    output logic [NCH-1:0]      in_ready,
    input  logic                force_en,
    input  logic [CW-1:0]       force_sel,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [CW-1:0]       out_ch,
    input  logic                out_ready
);

    logic [CW-1:0]  r_ptr;
    logic           r_out_valid;
    logic [DW-1:0]  r_out_data;
    logic [CW-1:0]  r_out_ch;

    logic [NCH-1:0] w_grant;
    logic           w_found;
    logic [CW:0]    w_idx;
    logic           w_any;
    logic [CW-1:0]  w_gidx;
    logic [DW-1:0]  w_gdata;
    logic           w_ld;
    logic [CW-1:0]  w_ptr_next;

    // The output stage can take a beat when it is empty or being drained now.
    assign w_ld = !r_out_valid || out_ready;

    // Arbiter: one-hot-or-zero grant from force, fixed-priority or round-robin.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (force_en) begin
            // Out-of-range forced selects grant nothing.
            if ({1'b0, force_sel} < (CW+1)'(NCH)) begin
                w_grant[force_sel] = in_valid[force_sel];
            end else begin
                w_grant = '0;
            end
        end else if (FIXED_PRI != 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (!w_found && in_valid[i]) begin
                    w_grant[i] = 1'b1;
                    w_found    = 1'b1;
                end else begin
                    w_found    = w_found;
                end
            end
        end else begin
            // Search ptr, ptr+1, ... wrapping modulo NCH.
            for (int k = 0; k < NCH; k++) begin
                w_idx = {1'b0, r_ptr} + (CW+1)'(k);
                if (w_idx >= (CW+1)'(NCH)) begin
                    w_idx = w_idx - (CW+1)'(NCH);
                end else begin
                    w_idx = w_idx;
                end
                if (!w_found && in_valid[w_idx[CW-1:0]]) begin
                    w_grant[w_idx[CW-1:0]] = 1'b1;
                    w_found                = 1'b1;
                end else begin
                    w_found                = w_found;
                end
            end
        end
    end

    // Encode the granted channel index and pick its data.
    always_comb begin
        w_any   = |w_grant;
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_gidx  = CW'(i);
                w_gdata = in_data[i*DW +: DW];
            end else begin
                w_gidx  = w_gidx;
            end
        end
    end

    // Pointer moves just past the winner, wrapping after the last channel.
    always_comb begin
        if (w_gidx == CW'(NCH-1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_gidx + CW'(1);
        end
    end

    // Accept strobe: only the granted channel, only while the stage can load,
    // and never while reset is asserted.
    always_comb begin
        if (rst || !w_ld) begin
            in_ready = '0;
        end else begin
            in_ready = w_grant;
        end
    end

    // Output stage and round-robin pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_ld) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_ch    <= w_gidx;
                // Forced and fixed-priority transfers leave the pointer alone.
                if (!force_en && (FIXED_PRI == 0)) begin
                    r_ptr <= w_ptr_next;
                end else begin
                    r_ptr <= r_ptr;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr: one round-robin and one
// fixed-priority instance share the same input stimulus.
module tb_stream_mux_rr;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic              force_en;
    logic [CW-1:0]     force_sel;
    logic              out_ready;

    logic [NCH-1:0]    rr_in_ready, fp_in_ready;
    logic              rr_out_valid, fp_out_valid;
    logic [DW-1:0]     rr_out_data, fp_out_data;
    logic [CW-1:0]     rr_out_ch, fp_out_ch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.NCH(NCH), .DW(DW), .FIXED_PRI(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_ch(rr_out_ch),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.NCH(NCH), .DW(DW), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_ch(fp_out_ch),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rr_out(input string tag, input logic v, input logic [CW-1:0] ch, input logic [DW-1:0] d);
        check({tag, "_valid"}, 32'(rr_out_valid), 32'(v));
        check({tag, "_ch"},    32'(rr_out_ch),    32'(ch));
        check({tag, "_data"},  32'(rr_out_data),  32'(d));
    endtask

    logic [CW-1:0] exp_ch [0:4];
    logic [DW-1:0] exp_d  [0:4];

    initial begin
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd3; exp_ch[4] = 2'd0;
        exp_d[0] = 8'h00; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33; exp_d[4] = 8'h00;

        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        force_en  = 1'b0;
        force_sel = 2'd0;
        out_ready = 1'b1;

        // Reset held for two cycles with every channel requesting.
        tick();
        check("rst_in_ready", 32'(rr_in_ready), 32'h0);
        tick();
        check("rst_in_ready2", 32'(rr_in_ready), 32'h0);
        check_rr_out("rst", 1'b0, 2'd0, 8'h00);

        // Round-robin fairness with all channels valid.
        rst = 1'b0;
        #1;
        check("rr_first_grant", 32'(rr_in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_rr_out($sformatf("rr_seq%0d", i), 1'b1, exp_ch[i], exp_d[i]);
        end
        // ptr = 1: next loads ch1, then ch2.
        tick();
        check_rr_out("rr_seq5", 1'b1, 2'd1, 8'h11);
        tick();
        check_rr_out("rr_seq6", 1'b1, 2'd2, 8'h22);

        // Skip and wrap: only ch0/ch1 valid, ptr = 3.
        in_valid = 4'b0011;
        #1;
        check("wrap_ready", 32'(rr_in_ready), 32'b0001);
        tick();
        check_rr_out("wrap_ch0", 1'b1, 2'd0, 8'h00);
        tick();
        check_rr_out("wrap_ch1", 1'b1, 2'd1, 8'h11);

        // Backpressure: hold beat ch1/0x11 for three cycles.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), 32'(rr_in_ready), 32'h0);
            tick();
            check_rr_out($sformatf("bp_hold%0d", i), 1'b1, 2'd1, 8'h11);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(rr_in_ready), 32'b0100);
        tick();
        check_rr_out("bp_release", 1'b1, 2'd2, 8'h22);

        // Force ch3 repeatedly; ptr stays at 3.
        force_en  = 1'b1;
        force_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("force_ready%0d", i), 32'(rr_in_ready), 32'b1000);
            tick();
            check_rr_out($sformatf("force_out%0d", i), 1'b1, 2'd3, 8'h33);
        end
        // Forced channel not valid: no transfer, beat drains.
        force_sel = 2'd2;
        in_valid  = 4'b1011;
        #1;
        check("force_idle_ready", 32'(rr_in_ready), 32'h0);
        tick();
        check_rr_out("force_idle", 1'b0, 2'd3, 8'h33);

        // Release force: pointer still 3, so ch3 wins over ch0.
        force_en = 1'b0;
        in_valid = 4'b1111;
        #1;
        check("ptr_kept_ready", 32'(rr_in_ready), 32'b1000);
        tick();
        check_rr_out("ptr_kept", 1'b1, 2'd3, 8'h33);
        tick();
        check_rr_out("after_wrap", 1'b1, 2'd0, 8'h00);

        // Reset mid-operation with ptr = 1 and a pending beat.
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(rr_in_ready), 32'h0);
        tick();
        check_rr_out("midrst", 1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        #1;
        check("midrst_ptr0", 32'(rr_in_ready), 32'b0001);

        // Fixed-priority instance: reset, then lowest index always wins.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 4'b1010;
        #1;
        check("fp_ready_a", 32'(fp_in_ready), 32'b0010);
        tick();
        check("fp_ch_a",   32'(fp_out_ch),   32'd1);
        check("fp_data_a", 32'(fp_out_data), 32'h11);
        in_valid = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("fp_ready_b%0d", i), 32'(fp_in_ready), 32'b0010);
            tick();
            check($sformatf("fp_ch_b%0d", i),    32'(fp_out_ch),    32'd1);
            check($sformatf("fp_valid_b%0d", i), 32'(fp_out_valid), 32'd1);
        end
        in_valid = 4'b1000;
        #1;
        check("fp_ready_c", 32'(fp_in_ready), 32'b1000);
        tick();
        check("fp_ch_c",   32'(fp_out_ch),   32'd3);
        check("fp_data_c", 32'(fp_out_data), 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
